ws2812_serializer: RTL

//  Downstream stage of the LED colour pipeline. Accepts gamma-corrected colour bytes over a valid/ready

---
 rtl/ws2812_serializer_pkg.sv | 15 +
 rtl/ws2812_bit_encoder.sv | 57 +++++
 rtl/ws2812_serializer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ws2812_serializer_pkg.sv
// ws2812_serializer_pkg: shared WS2812 timing defaults, timing legality rule and FSM state type
package ws2812_serializer_pkg;

    localparam int T0H_DEF    = 4;
    localparam int T1H_DEF    = 8;
    localparam int TBIT_DEF   = 15;
    localparam int TLATCH_DEF = 960;

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_LATCH} state_e;

    function automatic bit timing_ok(input int t0h, input int t1h, input int tbit, input int tlatch);
        return t0h >= 1 && t0h < t1h && t1h < tbit && tlatch >= tbit;
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder: times one WS2812 bit period (high phase then low phase)
//  clk_i/rst_ni : clock, asynchronous active-low reset
//  start_i      : begin a new bit now (may coincide with done_o of the previous bit)
//  bit_i        : value of the bit being started
//  dout_o       : registered line level
//  hi_end_o     : this edge ends the high phase
//  done_o       : this edge ends the whole bit period
module ws2812_bit_encoder #(
    parameter int T0H  = 4,
    parameter int T1H  = 8,
    parameter int TBIT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic bit_i,
    output logic dout_o,
    output logic hi_end_o,
    output logic done_o
);
    localparam int PW = $clog2(TBIT + 1);
    localparam logic [PW-1:0] H0 = PW'(T0H - 1);
    localparam logic [PW-1:0] H1 = PW'(T1H - 1);
    localparam logic [PW-1:0] L0 = PW'(TBIT - T0H - 1);
    localparam logic [PW-1:0] L1 = PW'(TBIT - T1H - 1);

    logic [PW-1:0] ph_q;
    logic          act_q, hi_q, bit_q;
    logic [PW-1:0] lim;

    assign lim      = hi_q ? (bit_q ? H1 : H0) : (bit_q ? L1 : L0);
    assign hi_end_o = act_q && hi_q && ph_q == lim;
    assign done_o   = act_q && !hi_q && ph_q == lim;
    assign dout_o   = hi_q;

    // At the end of the high phase act stays set; at the end of the low phase it clears.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_q <= 1'b0;
            hi_q  <= 1'b0;
            bit_q <= 1'b0;
            ph_q  <= '0;
        end else if (start_i) begin
            act_q <= 1'b1;
            hi_q  <= 1'b1;
            bit_q <= bit_i;
            ph_q  <= '0;
        end else if (act_q) begin
            ph_q <= (ph_q == lim) ? '0 : ph_q + 1'b1;
            if (ph_q == lim) begin
                hi_q  <= 1'b0;
                act_q <= hi_q;
            end
        end
    end

endmodule

// File: rtl/ws2812_serializer.sv
// ws2812_serializer: byte stream to WS2812 NRZ bitstream with one-byte holding buffer and latch period
//  clk_i/rst_ni              : clock, asynchronous active-low reset
//  s_valid_i/s_data_i/s_last_i : upstream byte, MSB sent first, last marks end of frame
//  s_ready_o                 : holding buffer empty
//  dout_o                    : WS2812 data line
//  busy_o                    : not idle
//  frame_done_o              : one-cycle pulse at end of latch period
//  underrun_o                : one-cycle pulse when a byte ends with no successor and no last flag
module ws2812_serializer
    import ws2812_serializer_pkg::*;
#(
    parameter int T0H    = T0H_DEF,
    parameter int T1H    = T1H_DEF,
    parameter int TBIT   = TBIT_DEF,
    parameter int TLATCH = TLATCH_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       s_valid_i,
    input  logic [7:0] s_data_i,
    input  logic       s_last_i,
    output logic       s_ready_o,
    output logic       dout_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       underrun_o
);
    localparam int LW = $clog2(TLATCH + 1);
    localparam logic [LW-1:0] LC_END = LW'(TLATCH - 1);

    if (!timing_ok(T0H, T1H, TBIT, TLATCH)) begin : g_bad_timing
        $error("ws2812_serializer: need 1<=T0H<T1H<TBIT and TLATCH>=TBIT");
    end

    state_e        state_q;
    logic [7:0]    buf_q;
    logic          buf_last_q, full_q, full_d;
    logic [6:0]    sh_q;
    logic          sh_last_q;
    logic [2:0]    bi_q;
    logic [LW-1:0] lc_q;
    logic          ready_q, busy_q, done_q, ur_q;
    logic          accept, load, next_bit, start, enc_bit, hi_end, bit_done;

    assign accept   = s_valid_i && ready_q;
    assign load     = full_q && (state_q == ST_IDLE || (state_q == ST_LOW && bit_done && bi_q == 3'd0));
    assign next_bit = state_q == ST_LOW && bit_done && bi_q != 3'd0;
    assign start    = load || next_bit;
    // The MSB of a freshly loaded byte goes straight from the buffer; the shifter keeps the remaining 7 bits.
    assign enc_bit  = load ? buf_q[7] : sh_q[6];
    assign full_d   = accept || (full_q && !load);

    assign s_ready_o    = ready_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign underrun_o   = ur_q;

    ws2812_bit_encoder #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT)) u_enc (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start),
        .bit_i    (enc_bit),
        .dout_o   (dout_o),
        .hi_end_o (hi_end),
        .done_o   (bit_done)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            buf_last_q <= 1'b0;
            full_q     <= 1'b0;
            sh_q       <= '0;
            sh_last_q  <= 1'b0;
            bi_q       <= '0;
            lc_q       <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ur_q       <= 1'b0;
        end else begin
            full_q  <= full_d;
            ready_q <= !full_d;
            done_q  <= 1'b0;
            ur_q    <= 1'b0;
            if (accept) begin
                buf_q      <= s_data_i;
                buf_last_q <= s_last_i;
            end
            if (load) begin
                sh_q      <= buf_q[6:0];
                sh_last_q <= buf_last_q;
                bi_q      <= 3'd7;
            end else if (next_bit) begin
                sh_q <= {sh_q[5:0], 1'b0};
                bi_q <= bi_q - 1'b1;
            end
            case (state_q)
                ST_IDLE: if (full_q) begin
                    state_q <= ST_HIGH;
                    busy_q  <= 1'b1;
                end
                ST_HIGH: if (hi_end) state_q <= ST_LOW;
                ST_LOW: if (bit_done) begin
                    state_q <= start ? ST_HIGH : ST_LATCH;
                    ur_q    <= !start && !sh_last_q;
                    lc_q    <= '0;
                end
                ST_LATCH: if (lc_q == LC_END) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    lc_q <= lc_q + 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
